lap_stopwatch: RTL and testbench

Next-generation stopwatch for the FPGA clock board. It counts MM:SS:CC from a prescaled system clock and captures lap times into a circular buffer of depth LAP_DEPTH. It drives the two 2-digit LED groups with live time (SS:CC or MM:SS) or recalled laps. All control is synchronous to clock; it takes single-cycle button pulses from the existing debounce/edge blocks.

---
 rtl/lap_stopwatch_pkg.sv | 25 ++
 rtl/lap_ring_buffer.sv | 50 +++++
 rtl/lap_stopwatch.sv | 190 +++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_stopwatch_pkg.sv
// Shared constants, run-state encoding and width helpers for the lap stopwatch.
package lap_stopwatch_pkg;

    localparam logic VIEW_SSCC = 1'b0;
    localparam logic VIEW_MMSS = 1'b1;

    typedef enum logic [1:0] {
        ST_PAUSED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_OVERFLOW = 2'd2
    } run_state_t;

    function automatic int rec_w(input int field_w);
        return 3 * field_w;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/lap_ring_buffer.sv
// Circular lap store: wrapping write pointer that overwrites the oldest entry,
// saturating valid count, combinational read addressed by age (0 = newest).
module lap_ring_buffer
    import lap_stopwatch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 21
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [ptr_w(DEPTH)-1:0]    rd_age,
    output logic [WIDTH-1:0]           rd_data,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            count <= '0;
        end else if (clear) begin
            wp    <= '0;
            count <= '0;
        end else if (wr_en) begin
            wp <= wp + PW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end
    end

    // Storage is never read before being written, so it carries no reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wp] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer arithmetic wraps naturally.
    assign rd_data = mem[wp - PW'(1) - rd_age];

endmodule

// File: rtl/lap_stopwatch.sv
// MM:SS:CC stopwatch with lap capture, lap recall and registered two-field display.
//   state       | meaning
//   ST_PAUSED   | time held, clear accepted, run starts counting
//   ST_RUNNING  | prescaler and time cascade advance, laps accepted
//   ST_OVERFLOW | time saturated at max; only clear leaves
module lap_stopwatch
    import lap_stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 5000,
    parameter int CS_LIMIT  = 100,
    parameter int SEC_LIMIT = 60,
    parameter int MIN_LIMIT = 60,
    parameter int FIELD_W   = 7,
    parameter int LAP_DEPTH = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            btn_run,
    input  logic                            btn_lap,
    input  logic                            btn_view,
    input  logic                            btn_recall,
    input  logic                            btn_clear,
    output logic [FIELD_W-1:0]              disp_hi,
    output logic [FIELD_W-1:0]              disp_lo,
    output logic                            disp_dot,
    output logic                            running,
    output logic                            overflow,
    output logic                            recall_active,
    output logic [ptr_w(LAP_DEPTH)-1:0]     recall_idx,
    output logic [cnt_w(LAP_DEPTH)-1:0]     lap_count
);

    localparam int RW = rec_w(FIELD_W);
    localparam int CW = cnt_w(LAP_DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]      TICK_TC = TW'(TICK_DIV - 1);
    localparam logic [FIELD_W-1:0] CS_TC   = FIELD_W'(CS_LIMIT - 1);
    localparam logic [FIELD_W-1:0] SEC_TC  = FIELD_W'(SEC_LIMIT - 1);
    localparam logic [FIELD_W-1:0] MIN_TC  = FIELD_W'(MIN_LIMIT - 1);

    run_state_t state_q, state_d;

    logic [TW-1:0]      presc_q;
    logic [FIELD_W-1:0] cs_q, sec_q, min_q;
    logic               view_q, auto_sw_q;
    logic               clear_ok, tick, at_max, lap_wr;
    logic [RW-1:0]      lap_rec, src_rec;
    logic [FIELD_W-1:0] src_min, src_sec, src_cs;

    assign clear_ok = btn_clear && (state_q != ST_RUNNING);
    assign tick     = (state_q == ST_RUNNING) && (presc_q == TICK_TC);
    assign at_max   = (min_q == MIN_TC) && (sec_q == SEC_TC) && (cs_q == CS_TC);
    assign lap_wr   = btn_lap && (state_q == ST_RUNNING);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_PAUSED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PAUSED: begin
                if (!clear_ok && btn_run) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (tick && at_max) begin
                    state_d = ST_OVERFLOW;
                end else if (btn_run) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_OVERFLOW: begin
                if (clear_ok) begin
                    state_d = ST_PAUSED;
                end
            end
            default: state_d = ST_PAUSED;
        endcase
    end

    always_comb begin
        running  = (state_q == ST_RUNNING);
        overflow = (state_q == ST_OVERFLOW);
    end

    // A tick at the maximum leaves the time untouched; the FSM saturates instead.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            cs_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
        end else if (clear_ok) begin
            presc_q <= '0;
            cs_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
        end else if (state_q == ST_RUNNING) begin
            if (presc_q == TICK_TC) begin
                presc_q <= '0;
                if (!at_max) begin
                    if (cs_q == CS_TC) begin
                        cs_q <= '0;
                        if (sec_q == SEC_TC) begin
                            sec_q <= '0;
                            min_q <= min_q + FIELD_W'(1);
                        end else begin
                            sec_q <= sec_q + FIELD_W'(1);
                        end
                    end else begin
                        cs_q <= cs_q + FIELD_W'(1);
                    end
                end
            end else begin
                presc_q <= presc_q + TW'(1);
            end
        end
    end

    lap_ring_buffer #(
        .DEPTH (LAP_DEPTH),
        .WIDTH (RW)
    ) u_laps (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear_ok),
        .wr_en   (lap_wr),
        .wr_data ({min_q, sec_q, cs_q}),
        .rd_age  (recall_idx),
        .rd_data (lap_rec),
        .count   (lap_count)
    );

    // Auto-switch to MM:SS fires once per clear/reset and overrides a same-cycle view press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            recall_active <= 1'b0;
            recall_idx    <= '0;
            view_q        <= VIEW_SSCC;
            auto_sw_q     <= 1'b0;
        end else if (clear_ok) begin
            recall_active <= 1'b0;
            recall_idx    <= '0;
            view_q        <= VIEW_SSCC;
            auto_sw_q     <= 1'b0;
        end else begin
            if (btn_recall && (lap_count != '0)) begin
                if (!recall_active) begin
                    recall_active <= 1'b1;
                    recall_idx    <= '0;
                end else if ({1'b0, recall_idx} == lap_count - CW'(1)) begin
                    recall_active <= 1'b0;
                    recall_idx    <= '0;
                end else begin
                    recall_idx <= recall_idx + 1'b1;
                end
            end
            if (!auto_sw_q && (min_q != '0)) begin
                auto_sw_q <= 1'b1;
                view_q    <= VIEW_MMSS;
            end else if (btn_view) begin
                view_q <= ~view_q;
            end
        end
    end

    assign src_rec = recall_active ? lap_rec : {min_q, sec_q, cs_q};
    assign src_min = src_rec[3*FIELD_W-1:2*FIELD_W];
    assign src_sec = src_rec[2*FIELD_W-1:FIELD_W];
    assign src_cs  = src_rec[FIELD_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_hi  <= '0;
            disp_lo  <= '0;
            disp_dot <= 1'b0;
        end else begin
            disp_hi  <= (view_q == VIEW_MMSS) ? src_min : src_sec;
            disp_lo  <= (view_q == VIEW_MMSS) ? src_sec : src_cs;
            disp_dot <= (src_min != '0);
        end
    end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: directed scenarios plus randomized buttons against a
// time-in-centiseconds reference model with a lap queue.
module tb_lap_stopwatch;

    localparam int TD    = 4;
    localparam int CS_L  = 100;
    localparam int SEC_L = 60;
    localparam int MIN_L = 2;
    localparam int FW    = 7;
    localparam int DEPTH = 4;
    localparam int MAXT  = MIN_L * SEC_L * CS_L - 1;

    localparam logic [4:0] B_CLR  = 5'b10000;
    localparam logic [4:0] B_RUN  = 5'b01000;
    localparam logic [4:0] B_LAP  = 5'b00100;
    localparam logic [4:0] B_REC  = 5'b00010;
    localparam logic [4:0] B_VIEW = 5'b00001;
    localparam logic [4:0] B_NONE = 5'b00000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn_run = 1'b0, btn_lap = 1'b0, btn_view = 1'b0, btn_recall = 1'b0, btn_clear = 1'b0;
    logic [FW-1:0] disp_hi, disp_lo;
    logic disp_dot, running, overflow, recall_active;
    logic [1:0] recall_idx;
    logic [2:0] lap_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lap_stopwatch #(
        .TICK_DIV (TD),
        .CS_LIMIT (CS_L),
        .SEC_LIMIT(SEC_L),
        .MIN_LIMIT(MIN_L),
        .FIELD_W  (FW),
        .LAP_DEPTH(DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_run      (btn_run),
        .btn_lap      (btn_lap),
        .btn_view     (btn_view),
        .btn_recall   (btn_recall),
        .btn_clear    (btn_clear),
        .disp_hi      (disp_hi),
        .disp_lo      (disp_lo),
        .disp_dot     (disp_dot),
        .running      (running),
        .overflow     (overflow),
        .recall_active(recall_active),
        .recall_idx   (recall_idx),
        .lap_count    (lap_count)
    );

    // Reference model: total elapsed centiseconds plus a queue of lap times (newest at back).
    int m_t, m_presc, m_run, m_ovf, m_view, m_auto, m_rec, m_ridx;
    int e_hi, e_lo, e_dot;
    int laps[$];

    function automatic int f_min(input int t); return t / (CS_L * SEC_L); endfunction
    function automatic int f_sec(input int t); return (t / CS_L) % SEC_L; endfunction
    function automatic int f_cs (input int t); return t % CS_L;           endfunction

    task automatic mdl_reset();
        m_t = 0; m_presc = 0; m_run = 0; m_ovf = 0;
        m_view = 0; m_auto = 0; m_rec = 0; m_ridx = 0;
        e_hi = 0; e_lo = 0; e_dot = 0;
        laps.delete();
    endtask

    task automatic mdl_step(input logic [4:0] b);
        int src, cnt;
        bit tk;
        cnt = laps.size();
        src = (m_rec != 0) ? laps[cnt - 1 - m_ridx] : m_t;
        e_hi  = (m_view != 0) ? f_min(src) : f_sec(src);
        e_lo  = (m_view != 0) ? f_sec(src) : f_cs(src);
        e_dot = (f_min(src) > 0) ? 1 : 0;
        if (b[4] && m_run == 0) begin
            m_t = 0; m_presc = 0; m_ovf = 0; m_view = 0; m_auto = 0; m_rec = 0; m_ridx = 0;
            laps.delete();
        end else begin
            if (b[2] && m_run != 0) begin
                laps.push_back(m_t);
                if (laps.size() > DEPTH) void'(laps.pop_front());
            end
            if (b[1] && cnt > 0) begin
                if (m_rec == 0) begin m_rec = 1; m_ridx = 0; end
                else if (m_ridx == cnt - 1) begin m_rec = 0; m_ridx = 0; end
                else m_ridx = m_ridx + 1;
            end
            if (m_auto == 0 && f_min(m_t) > 0) begin m_auto = 1; m_view = 1; end
            else if (b[0]) m_view = (m_view != 0) ? 0 : 1;
            tk = (m_run != 0) && (m_presc == TD - 1);
            if (m_run != 0) m_presc = tk ? 0 : m_presc + 1;
            if (b[3] && m_ovf == 0) m_run = (m_run != 0) ? 0 : 1;
            if (tk) begin
                if (m_t == MAXT) begin m_ovf = 1; m_run = 0; end
                else m_t = m_t + 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [4:0] b);
        {btn_clear, btn_run, btn_lap, btn_recall, btn_view} = b;
        mdl_step(b);
        @(posedge clock);
        #1;
        {btn_clear, btn_run, btn_lap, btn_recall, btn_view} = B_NONE;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(B_NONE);
    endtask

    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (m_t != target && n < budget) begin
            cyc(B_NONE);
            n++;
        end
        if (m_t != target) begin
            checks++;
            errors++;
            $display("FAIL run_until: time %0d expected %0d within %0d cycles", m_t, target, budget);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {btn_clear, btn_run, btn_lap, btn_recall, btn_view} = B_NONE;
        mdl_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_hi"},    int'(disp_hi),       e_hi);
        chk({tag, "_lo"},    int'(disp_lo),       e_lo);
        chk({tag, "_dot"},   int'(disp_dot),      e_dot);
        chk({tag, "_run"},   int'(running),       m_run);
        chk({tag, "_ovf"},   int'(overflow),      m_ovf);
        chk({tag, "_rec"},   int'(recall_active), m_rec);
        chk({tag, "_ridx"},  int'(recall_idx),    m_ridx);
        chk({tag, "_count"}, int'(lap_count),     laps.size());
    endtask

    typedef struct {
        logic [4:0] b;
        int hi;
        int lo;
        int rec;
        int idx;
    } rec_vec_t;

    rec_vec_t tbl[7];

    initial begin
        tbl[0] = '{B_REC,  0, 60, 1, 0};
        tbl[1] = '{B_REC,  0, 50, 1, 1};
        tbl[2] = '{B_VIEW, 0,  0, 1, 1};
        tbl[3] = '{B_VIEW, 0, 50, 1, 1};
        tbl[4] = '{B_REC,  0, 40, 1, 2};
        tbl[5] = '{B_REC,  0, 30, 1, 3};
        tbl[6] = '{B_REC,  0, 60, 0, 0};

        do_reset();
        chk("rst_hi", int'(disp_hi), 0);
        chk("rst_lo", int'(disp_lo), 0);
        chk("rst_run", int'(running), 0);
        chk("rst_count", int'(lap_count), 0);

        // 400 running cycles = 100 ticks = 00:01:00, one extra cycle for display latency
        cyc(B_RUN);
        idle(400);
        chk("t1_run", int'(running), 1);
        idle(1);
        chk("t1_hi", int'(disp_hi), 1);
        chk("t1_lo", int'(disp_lo), 0);
        chk("t1_dot", int'(disp_dot), 0);

        // clear ignored while running; lap+run at 00:05:07
        cyc(B_CLR);
        idle(1);
        chk("t5_clr_ign_run", int'(running), 1);
        chk("t5_clr_ign_hi", int'(disp_hi), 1);
        run_until(507, 3000);
        cyc(B_LAP | B_RUN);
        chk("t5_paused", int'(running), 0);
        chk("t5_count", int'(lap_count), 1);
        cyc(B_REC);
        idle(1);
        chk("t5_rec", int'(recall_active), 1);
        chk("t5_hi", int'(disp_hi), 5);
        chk("t5_lo", int'(disp_lo), 7);
        cyc(B_REC);
        chk("t5_live", int'(recall_active), 0);
        cyc(B_CLR);
        idle(1);
        chk("clr_hi", int'(disp_hi), 0);
        chk("clr_lo", int'(disp_lo), 0);
        chk("clr_count", int'(lap_count), 0);

        // six laps into a depth-4 ring, then recall walk
        cyc(B_RUN);
        for (int k = 1; k <= 6; k++) begin
            run_until(10 * k, 100);
            cyc(B_LAP);
        end
        cyc(B_RUN);
        chk("t3_run", int'(running), 0);
        chk("t3_count", int'(lap_count), DEPTH);
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].b);
            idle(1);
            chk($sformatf("t3_hi_%0d", i),   int'(disp_hi),       tbl[i].hi);
            chk($sformatf("t3_lo_%0d", i),   int'(disp_lo),       tbl[i].lo);
            chk($sformatf("t3_rec_%0d", i),  int'(recall_active), tbl[i].rec);
            chk($sformatf("t3_idx_%0d", i),  int'(recall_idx),    tbl[i].idx);
            chk($sformatf("t3_cnt_%0d", i),  int'(lap_count),     DEPTH);
        end

        // auto-switch at 01:00:00
        cyc(B_CLR);
        cyc(B_RUN);
        run_until(6000, 30000);
        cyc(B_RUN);
        idle(2);
        chk("t2_hi", int'(disp_hi), 1);
        chk("t2_lo", int'(disp_lo), 0);
        chk("t2_dot", int'(disp_dot), 1);
        cyc(B_VIEW);
        idle(2);
        chk("t2_sscc_hi", int'(disp_hi), 0);
        chk("t2_sscc_lo", int'(disp_lo), 0);
        chk("t2_sscc_dot", int'(disp_dot), 1);

        // saturation at 01:59:99
        cyc(B_RUN);
        run_until(MAXT, 30000);
        idle(6);
        chk("t4_ovf", int'(overflow), 1);
        chk("t4_run", int'(running), 0);
        chk("t4_hi", int'(disp_hi), 59);
        chk("t4_lo", int'(disp_lo), 99);
        cyc(B_RUN);
        idle(1);
        chk("t4_run_ign", int'(running), 0);
        chk("t4_ovf_hold", int'(overflow), 1);
        chk("t4_hold_lo", int'(disp_lo), 99);
        cyc(B_CLR);
        idle(1);
        chk("t4_clr_ovf", int'(overflow), 0);
        chk("t4_clr_hi", int'(disp_hi), 0);
        chk("t4_clr_lo", int'(disp_lo), 0);
        chk("t4_clr_dot", int'(disp_dot), 0);

        // async reset mid-count with two laps stored
        cyc(B_RUN);
        run_until(200, 1000);
        cyc(B_LAP);
        run_until(300, 1000);
        cyc(B_LAP);
        run_until(342, 1000);
        chk("t6_count_pre", int'(lap_count), 2);
        #2 reset = 1'b1;
        #1;
        chk("t6_hi", int'(disp_hi), 0);
        chk("t6_lo", int'(disp_lo), 0);
        chk("t6_dot", int'(disp_dot), 0);
        chk("t6_run", int'(running), 0);
        chk("t6_ovf", int'(overflow), 0);
        chk("t6_count", int'(lap_count), 0);
        chk("t6_ridx", int'(recall_idx), 0);
        mdl_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        cyc(B_REC);
        idle(1);
        chk("t6_rec_ign", int'(recall_active), 0);
        chk("t6_count_post", int'(lap_count), 0);

        // randomized buttons against the model
        do_reset();
        chk_all("rnd_rst");
        for (int i = 0; i < 4000; i++) begin
            logic [4:0] b;
            b[4] = ($urandom_range(0, 31) == 0);
            b[3] = ($urandom_range(0, 11) == 0);
            b[2] = ($urandom_range(0, 5) == 0);
            b[1] = ($urandom_range(0, 7) == 0);
            b[0] = ($urandom_range(0, 9) == 0);
            cyc(b);
            chk_all("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
